// File: rtl/alu_seq.sv
// alu_seq: registered ALU stage between register-file read and writeback.
//
// It supports eight operations plus a load-constant path, with valid/ready
// handshakes on both sides. Carry and Zero flags are produced alongside the
// result. Shifts are done serially, one bit per cycle, so wide builds need
// no barrel shifter.
//
// Ports
//   Clk       clock, all state on rising edge
//   Reset     asynchronous active-high reset
//   InValid   request valid
//   InReady   request can be accepted (IDLE only)
//   Ldcen     load-constant select, overrides Aluop
//   Aluop     000 AND, 001 ADD, 010 SUB(A-B), 011 OR,
//             100 SHL(B<<A), 101 SHR(B>>A), 110 CMP, 111 MOV(A)
//   LdcVal    load-constant immediate (MSB lands in result MSB)
//   DatA      operand A (shift amount for SHL/SHR)
//   DatB      operand B (value shifted for SHL/SHR)
//   OutValid  Rslt/Carry/Zero valid, held until OutReady
//   OutReady  consumer takes the result
//   Rslt      registered result
//   Carry     ADD carry-out / SUB borrow, 0 for all other ops
//   Zero      Rslt == 0
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a request, InReady=1
// SHIFT | serial shift in progress, count_q holds the remaining bits
// DONE  | result presented on OutValid, waiting for OutReady

module alu_seq #(
    parameter int W     = 8,
    parameter int LDC_W = 5
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             InValid,
    output logic             InReady,
    input  logic             Ldcen,
    input  logic [2:0]       Aluop,
    input  logic [LDC_W-1:0] LdcVal,
    input  logic [W-1:0]     DatA,
    input  logic [W-1:0]     DatB,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [W-1:0]     Rslt,
    output logic             Carry,
    output logic             Zero
);

    localparam int CW = $clog2(W) + 1;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SHL = 3'b100;
    localparam logic [2:0] OP_SHR = 3'b101;
    localparam logic [2:0] OP_CMP = 3'b110;
    localparam logic [2:0] OP_MOV = 3'b111;

    localparam logic [W-1:0]  W_VEC   = W[W-1:0];
    localparam logic [CW-1:0] W_CNT   = W[CW-1:0];
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;

    logic [W-1:0]    rslt_q;
    logic            carry_q;
    logic            zero_q;
    logic [CW-1:0]   count_q;
    logic            dir_right_q;

    logic            accept;
    logic            is_shift;
    logic [CW-1:0]   shift_n;
    logic [W:0]      sum_ext;
    logic [W:0]      diff_ext;
    logic [W-1:0]    imm_rslt;
    logic            imm_carry;
    logic [W-1:0]    ldc_ext;
    logic [W-1:0]    shift_step;

    assign accept   = InValid & (state_q == S_IDLE);
    assign is_shift = (Aluop == OP_SHL) || (Aluop == OP_SHR);

    // Amounts of W or more saturate to W; the result is then all zeros.
    // Below W the amount fits in CW bits, so the low slice is exact.
    always_comb begin
        if (DatA >= W_VEC) begin
            shift_n = W_CNT;
        end else begin
            shift_n = DatA[CW-1:0];
        end
    end

    // Bit W of the extended difference is the unsigned borrow (A < B).
    assign sum_ext  = {1'b0, DatA} + {1'b0, DatB};
    assign diff_ext = {1'b0, DatA} - {1'b0, DatB};

    always_comb begin
        imm_rslt  = '0;
        imm_carry = 1'b0;
        case (Aluop)
            OP_AND:  imm_rslt = DatA & DatB;
            OP_ADD:  {imm_carry, imm_rslt} = sum_ext;
            OP_SUB:  {imm_carry, imm_rslt} = diff_ext;
            OP_OR:   imm_rslt = DatA | DatB;
            OP_CMP: begin
                imm_rslt[0] = (DatA != DatB);
                imm_rslt[1] = (DatA > DatB);
            end
            OP_MOV:  imm_rslt = DatA;
            default: imm_rslt = '0;
        endcase
    end

    // The constant's MSB goes to the result MSB and the remaining bits to
    // the bottom; everything in between stays zero.
    always_comb begin
        ldc_ext              = '0;
        ldc_ext[LDC_W-2:0]   = LdcVal[LDC_W-2:0];
        ldc_ext[W-1]         = LdcVal[LDC_W-1];
    end

    assign shift_step = dir_right_q ? {1'b0, rslt_q[W-1:1]} : {rslt_q[W-2:0], 1'b0};

    // State register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (!Ldcen && is_shift && (shift_n != '0)) begin
                        state_d = S_SHIFT;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_SHIFT: begin
                if (count_q == CNT_ONE) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (OutReady) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        InReady  = (state_q == S_IDLE);
        OutValid = (state_q == S_DONE);
    end

    assign Rslt  = rslt_q;
    assign Carry = carry_q;
    assign Zero  = zero_q;

    // Flags change only when the final result is written, never during a
    // shift.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rslt_q      <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            count_q     <= '0;
            dir_right_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (Ldcen) begin
                            rslt_q  <= ldc_ext;
                            carry_q <= 1'b0;
                            zero_q  <= (ldc_ext == '0);
                        end else if (is_shift) begin
                            rslt_q      <= DatB;
                            count_q     <= shift_n;
                            dir_right_q <= (Aluop == OP_SHR);
                            if (shift_n == '0) begin
                                carry_q <= 1'b0;
                                zero_q  <= (DatB == '0);
                            end
                        end else begin
                            rslt_q  <= imm_rslt;
                            carry_q <= imm_carry;
                            zero_q  <= (imm_rslt == '0);
                        end
                    end
                end
                S_SHIFT: begin
                    rslt_q  <= shift_step;
                    count_q <= count_q - CNT_ONE;
                    if (count_q == CNT_ONE) begin
                        carry_q <= 1'b0;
                        zero_q  <= (shift_step == '0);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       InValid;
    logic       InReady;
    logic       Ldcen;
    logic [2:0] Aluop;
    logic [4:0] LdcVal;
    logic [7:0] DatA;
    logic [7:0] DatB;
    logic       OutValid;
    logic       OutReady;
    logic [7:0] Rslt;
    logic       Carry;
    logic       Zero;

    logic        in_valid16 = 1'b0;
    logic        in_ready16;
    logic        ldcen16 = 1'b0;
    logic [2:0]  aluop16 = 3'b000;
    logic [4:0]  ldcval16 = 5'b00000;
    logic [15:0] data16 = 16'h0000;
    logic [15:0] datb16 = 16'h0000;
    logic        out_valid16;
    logic        out_ready16 = 1'b0;
    logic [15:0] rslt16;
    logic        carry16;
    logic        zero16;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    alu_seq #(.W(8), .LDC_W(5)) dut (
        .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady),
        .Ldcen(Ldcen), .Aluop(Aluop), .LdcVal(LdcVal), .DatA(DatA), .DatB(DatB),
        .OutValid(OutValid), .OutReady(OutReady), .Rslt(Rslt), .Carry(Carry), .Zero(Zero)
    );

    alu_seq #(.W(16), .LDC_W(5)) dut16 (
        .Clk(Clk), .Reset(Reset), .InValid(in_valid16), .InReady(in_ready16),
        .Ldcen(ldcen16), .Aluop(aluop16), .LdcVal(ldcval16), .DatA(data16), .DatB(datb16),
        .OutValid(out_valid16), .OutReady(out_ready16), .Rslt(rslt16), .Carry(carry16), .Zero(zero16)
    );

    // Reference model (W=8): result, carry and accept-to-OutValid latency.
    function automatic void model(input bit ld, input int op, input int ldc, input int a,
                                  input int b, output int r, output int c, output int lat);
        int n;
        n   = (a > 8) ? 8 : a;
        r   = 0;
        c   = 0;
        lat = 1;
        if (ld) begin
            r = ((ldc / 16) % 2) * 128 + (ldc % 16);
        end else begin
            case (op)
                0: r = a & b;
                1: begin r = (a + b) % 256; c = (a + b > 255) ? 1 : 0; end
                2: begin r = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
                3: r = a | b;
                4: begin r = (b * (1 << n)) % 256; lat = 1 + n; end
                5: begin r = b / (1 << n); lat = 1 + n; end
                6: r = ((a != b) ? 1 : 0) + ((a > b) ? 2 : 0);
                default: r = a;
            endcase
        end
    endfunction

    // Issue one request and wait (bounded) for OutValid; inputs are scrambled
    // right after the accept edge.
    task automatic do_op(input bit ld, input logic [2:0] op, input logic [4:0] ldc,
                         input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] r, output logic c, output logic z, output int lat);
        @(negedge Clk);
        Ldcen = ld; Aluop = op; LdcVal = ldc; DatA = a; DatB = b;
        InValid = 1'b1; OutReady = 1'b0;
        @(posedge Clk); #1;
        InValid = 1'b0; Ldcen = 1'b0;
        DatA = 8'($urandom); DatB = 8'($urandom); Aluop = 3'($urandom); LdcVal = 5'($urandom);
        lat = 1;
        while (OutValid !== 1'b1 && lat < 40) begin
            @(posedge Clk); #1;
            lat++;
        end
        r = Rslt; c = Carry; z = Zero;
    endtask

    task automatic retire();
        @(negedge Clk);
        OutReady = 1'b1;
        @(posedge Clk); #1;
        OutReady = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1; InValid = 1'b0; Ldcen = 1'b0; Aluop = 3'b000; LdcVal = 5'b0;
        DatA = 8'h00; DatB = 8'h00; OutReady = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        checks++;
        if (Rslt !== 8'h00 || Carry !== 1'b0 || Zero !== 1'b0 || OutValid !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got rslt=%h c=%b z=%b ov=%b want 00 0 0 0", Rslt, Carry, Zero, OutValid);
        end
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        checks++;
        if (InReady !== 1'b1) begin
            errors++;
            $display("FAIL reset_inready got %b want 1", InReady);
        end
    endtask

    task automatic test_directed();
        logic        ld_t  [9] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
        logic [2:0]  op_t  [9] = '{3'b001, 3'b010, 3'b010, 3'b110, 3'b100, 3'b101, 3'b100, 3'b001, 3'b111};
        logic [7:0]  a_t   [9] = '{8'hF0, 8'h05, 8'h03, 8'h09, 8'h03, 8'h09, 8'h00, 8'h33, 8'h00};
        logic [7:0]  b_t   [9] = '{8'h20, 8'h05, 8'h05, 8'h03, 8'h81, 8'hFF, 8'h5A, 8'h44, 8'h77};
        logic [7:0]  er_t  [9] = '{8'h10, 8'h00, 8'hFE, 8'h03, 8'h08, 8'h00, 8'h5A, 8'h86, 8'h00};
        logic        ec_t  [9] = '{1, 0, 1, 0, 0, 0, 0, 0, 0};
        logic        ez_t  [9] = '{0, 1, 0, 0, 0, 1, 0, 0, 1};
        int          el_t  [9] = '{1, 1, 1, 1, 4, 9, 1, 1, 1};
        logic [7:0] r;
        logic c, z;
        int lat;
        for (int i = 0; i < 9; i++) begin
            do_op(ld_t[i], op_t[i], 5'b10110, a_t[i], b_t[i], r, c, z, lat);
            checks++;
            if (r !== er_t[i] || c !== ec_t[i] || z !== ez_t[i]) begin
                errors++;
                $display("FAIL directed_%0d got rslt=%h c=%b z=%b want %h %b %b", i, r, c, z, er_t[i], ec_t[i], ez_t[i]);
            end
            checks++;
            if (lat != el_t[i]) begin
                errors++;
                $display("FAIL directed_latency_%0d got %0d want %0d", i, lat, el_t[i]);
            end
            retire();
            checks++;
            if (OutValid !== 1'b0 || InReady !== 1'b1) begin
                errors++;
                $display("FAIL directed_retire_%0d got ov=%b ir=%b want 0 1", i, OutValid, InReady);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] r;
        logic c, z;
        int lat, er, ec, el, a, b, op, ldc, hold;
        bit ld;
        for (int i = 0; i < 80; i++) begin
            ld  = ($urandom_range(0, 7) == 0);
            op  = $urandom_range(0, 7);
            ldc = $urandom_range(0, 31);
            a   = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 12) : $urandom_range(0, 255);
            b   = ($urandom_range(0, 5) == 0) ? a : $urandom_range(0, 255);
            model(ld, op, ldc, a, b, er, ec, el);
            do_op(ld, 3'(op), 5'(ldc), 8'(a), 8'(b), r, c, z, lat);
            checks++;
            if (r !== 8'(er) || c !== 1'(ec) || z !== (er == 0) || lat != el) begin
                errors++;
                $display("FAIL random_%0d ld=%0d op=%0d a=%h b=%h got rslt=%h c=%b z=%b lat=%0d want %h %0d %0d %0d",
                         i, ld, op, a, b, r, c, z, lat, er, ec, (er == 0), el);
            end
            hold = $urandom_range(0, 2);
            for (int k = 0; k < hold; k++) begin
                @(posedge Clk); #1;
                checks++;
                if (OutValid !== 1'b1 || Rslt !== 8'(er)) begin
                    errors++;
                    $display("FAIL random_hold_%0d got ov=%b rslt=%h want 1 %h", i, OutValid, Rslt, 8'(er));
                end
            end
            retire();
        end
    endtask

    task automatic test_stall();
        logic [7:0] r;
        logic c, z;
        int lat;
        do_op(1'b0, 3'b001, 5'b0, 8'h12, 8'h34, r, c, z, lat);
        for (int k = 0; k < 5; k++) begin
            @(negedge Clk);
            InValid = 1'b1; Aluop = 3'($urandom); DatA = 8'($urandom); DatB = 8'($urandom);
            @(posedge Clk); #1;
            checks++;
            if (Rslt !== 8'h46 || OutValid !== 1'b1 || InReady !== 1'b0 || Carry !== 1'b0 || Zero !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold_%0d got rslt=%h ov=%b ir=%b c=%b z=%b want 46 1 0 0 0",
                         k, Rslt, OutValid, InReady, Carry, Zero);
            end
        end
        @(negedge Clk);
        OutReady = 1'b1;
        @(posedge Clk); #1;
        checks++;
        if (OutValid !== 1'b0 || InReady !== 1'b1 || Rslt !== 8'h46) begin
            errors++;
            $display("FAIL stall_release got ov=%b ir=%b rslt=%h want 0 1 46", OutValid, InReady, Rslt);
        end
        @(negedge Clk);
        InValid = 1'b0; OutReady = 1'b0;
        @(posedge Clk); #1;
        checks++;
        if (OutValid !== 1'b0 || InReady !== 1'b1) begin
            errors++;
            $display("FAIL stall_no_second_accept got ov=%b ir=%b want 0 1", OutValid, InReady);
        end
    endtask

    task automatic test_reset_mid_shift();
        int seen;
        @(negedge Clk);
        Ldcen = 1'b0; Aluop = 3'b100; DatA = 8'h07; DatB = 8'h01; InValid = 1'b1;
        @(posedge Clk); #1;
        InValid = 1'b0;
        repeat (2) @(posedge Clk);
        #2;
        checks++;
        if (Rslt !== 8'h04 || OutValid !== 1'b0) begin
            errors++;
            $display("FAIL midshift_progress got rslt=%h ov=%b want 04 0", Rslt, OutValid);
        end
        Reset = 1'b1;
        #1;
        checks++;
        if (Rslt !== 8'h00 || Carry !== 1'b0 || Zero !== 1'b0 || OutValid !== 1'b0) begin
            errors++;
            $display("FAIL midshift_reset got rslt=%h c=%b z=%b ov=%b want 00 0 0 0", Rslt, Carry, Zero, OutValid);
        end
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        checks++;
        if (InReady !== 1'b1) begin
            errors++;
            $display("FAIL midshift_inready got %b want 1", InReady);
        end
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge Clk); #1;
            if (OutValid !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL midshift_stale_outvalid got %0d cycles high want 0", seen);
        end
    endtask

    task automatic test_ldc16();
        @(negedge Clk);
        ldcen16 = 1'b1; aluop16 = 3'b001; ldcval16 = 5'b10110;
        data16 = 16'h1234; datb16 = 16'h4321; in_valid16 = 1'b1;
        @(posedge Clk); #1;
        in_valid16 = 1'b0; ldcen16 = 1'b0;
        checks++;
        if (out_valid16 !== 1'b1 || rslt16 !== 16'h8006 || zero16 !== 1'b0 || carry16 !== 1'b0) begin
            errors++;
            $display("FAIL ldc_w16 got ov=%b rslt=%h z=%b c=%b want 1 8006 0 0", out_valid16, rslt16, zero16, carry16);
        end
        @(negedge Clk);
        out_ready16 = 1'b1;
        @(posedge Clk); #1;
        out_ready16 = 1'b0;
        checks++;
        if (out_valid16 !== 1'b0 || in_ready16 !== 1'b1) begin
            errors++;
            $display("FAIL ldc_w16_retire got ov=%b ir=%b want 0 1", out_valid16, in_ready16);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_random();
        test_reset_mid_shift();
        test_ldc16();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
